snitch_icache_perf_counters: RTL and testbench

Event sink for the instruction cache. Counts the per-port L0 event vectors (`icache_l0_events_t`) and the shared L1 event vector (`icache_l1_events_t`) that `snitch_icache_pkg` defines. Exposes the counts through a single-outstanding read/read-and-clear request/response port, with valid/ready on each side. Sits beside the cache in the cluster and feeds the cluster peripheral register file.

---
 rtl/snitch_icache_perf_counters.sv | 111 +++++++++++
 tb/tb_snitch_icache_perf_counters.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_perf_counters.sv
// rtl/snitch_icache_perf_counters.sv - saturating instruction-cache event counters with a read/read-and-clear port
// Event vector types come first so that the counter block compiles on its own.
package snitch_icache_pkg;
  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_miss;
    logic l1_hit;
    logic l1_stall;
    logic l1_handler_stall;
  } icache_l1_events_t;
endpackage

module snitch_icache_perf_counters #(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned COUNTER_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH     = 8
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   enable_i,
  input  snitch_icache_pkg::icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
  input  snitch_icache_pkg::icache_l1_events_t                   l1_events_i,
  input  logic                                                   req_valid_i,
  output logic                                                   req_ready_o,
  input  logic [ADDR_WIDTH-1:0]                                  req_addr_i,
  input  logic                                                   req_clear_i,
  output logic                                                   rsp_valid_o,
  input  logic                                                   rsp_ready_i,
  output logic [COUNTER_WIDTH-1:0]                               rsp_data_o,
  output logic                                                   rsp_error_o
);

  localparam int unsigned NUM_CNT = 5 * NR_FETCH_PORTS + 4;

  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0]       event_vec;
  logic [31:0]              addr_ext;
  logic                     accept;
  logic                     in_range;
  logic [COUNTER_WIDTH-1:0] rd_data;

  // Flatten the event structs into counter-index order.
  always_comb begin
    event_vec = '0;
    for (int p = 0; p < int'(NR_FETCH_PORTS); p++) begin
      event_vec[p*5+0] = l0_events_i[p].l0_miss;
      event_vec[p*5+1] = l0_events_i[p].l0_hit;
      event_vec[p*5+2] = l0_events_i[p].l0_prefetch;
      event_vec[p*5+3] = l0_events_i[p].l0_double_hit;
      event_vec[p*5+4] = l0_events_i[p].l0_stall;
    end
    event_vec[NUM_CNT-4] = l1_events_i.l1_miss;
    event_vec[NUM_CNT-3] = l1_events_i.l1_hit;
    event_vec[NUM_CNT-2] = l1_events_i.l1_stall;
    event_vec[NUM_CNT-1] = l1_events_i.l1_handler_stall;
  end

  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign addr_ext    = 32'(req_addr_i);
  assign in_range    = addr_ext < NUM_CNT;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      if (addr_ext == 32'(i)) rd_data = cnt_q[i];
    end
  end

  // A clear replaces the old value with zero, but this cycle's event still lands.
  always_comb begin
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      logic [COUNTER_WIDTH-1:0] base;
      base = cnt_q[i];
      if (accept && req_clear_i && in_range && (addr_ext == 32'(i))) base = '0;
      if (enable_i && event_vec[i] && (base != '1)) base = base + COUNTER_WIDTH'(1);
      cnt_d[i] = base;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_CNT); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CNT); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_error_o <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= in_range ? rd_data : '0;
      rsp_error_o <= !in_range;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// tb/tb_snitch_icache_perf_counters.sv - directed vector bench for snitch_icache_perf_counters
module tb_snitch_icache_perf_counters;
  import snitch_icache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  icache_l0_events_t [1:0] l0_ev = '0;
  icache_l1_events_t l1_ev = '0;
  logic req_valid = 1'b0;
  logic req_ready, req_ready4;
  logic [7:0] req_addr = '0;
  logic req_clear = 1'b0;
  logic rsp_ready = 1'b1;
  logic rsp_valid, rsp_valid4;
  logic [31:0] rsp_data;
  logic [3:0] rsp_data4;
  logic rsp_error, rsp_error4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snitch_icache_perf_counters #(.NR_FETCH_PORTS(2), .COUNTER_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .l0_events_i(l0_ev), .l1_events_i(l1_ev),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_clear_i(req_clear),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error)
  );

  snitch_icache_perf_counters #(.NR_FETCH_PORTS(2), .COUNTER_WIDTH(4), .ADDR_WIDTH(8)) dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .l0_events_i(l0_ev), .l1_events_i(l1_ev),
    .req_valid_i(req_valid), .req_ready_o(req_ready4), .req_addr_i(req_addr), .req_clear_i(req_clear),
    .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data4), .rsp_error_o(rsp_error4)
  );

  typedef struct {
    int          addr;
    bit          clr;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issues one request with rsp_ready held high; returns the response seen one cycle later.
  task automatic do_read(input int addr, input bit clr, output logic [63:0] d,
                         output logic [63:0] d4, output logic e);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 8'(addr);
    req_clear = clr;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("req_ready timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_clear = 1'b0;
    check($sformatf("rsp_valid addr %0d", addr), 64'(rsp_valid), 64'd1);
    d  = 64'(rsp_data);
    d4 = 64'(rsp_data4);
    e  = rsp_error;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, d4;
    logic e;

    for (int i = 0; i < 14; i++) begin
      tbl[i].addr = i;
      tbl[i].clr = 1'b0;
      tbl[i].exp_data = (i == 6) ? 64'd7 : 64'd0;
      tbl[i].exp_err = 1'b0;
    end
    tbl[14] = '{addr: 14, clr: 1'b0, exp_data: 64'd0, exp_err: 1'b1};
    tbl[15] = '{addr: 6,  clr: 1'b0, exp_data: 64'd7, exp_err: 1'b0};

    // Events during reset must not be counted.
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    l0_ev[1].l0_hit = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_data", 64'(rsp_data), 64'd0);
    check("reset rsp_error", 64'(rsp_error), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    l0_ev[1].l0_hit = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_read(tbl[i].addr, tbl[i].clr, d, d4, e);
      check($sformatf("tbl[%0d] data", i), d, tbl[i].exp_data);
      check($sformatf("tbl[%0d] error", i), 64'(e), 64'(tbl[i].exp_err));
    end

    // Read-and-clear with the event active in the accept cycle.
    do_reset();
    l1_ev.l1_stall = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 8'd12;
    req_clear = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_clear = 1'b0;
    check("rc12 pre-clear data", 64'(rsp_data), 64'd5);
    check("rc12 ready back-to-back", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    l1_ev.l1_stall = 1'b0;
    check("rc12 after clear data", 64'(rsp_data), 64'd1);

    // Saturation on the 4-bit instance.
    do_reset();
    l0_ev[0].l0_miss = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    l0_ev[0].l0_miss = 1'b0;
    do_read(0, 1'b0, d, d4, e);
    check("sat w32 data", d, 64'd20);
    check("sat w4 data", d4, 64'd15);
    @(negedge clk);
    l0_ev[0].l0_miss = 1'b1;
    req_valid = 1'b1;
    req_addr = 8'd0;
    req_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l0_ev[0].l0_miss = 1'b0;
    req_valid = 1'b0;
    req_clear = 1'b0;
    check("sat clear w4 data", 64'(rsp_data4), 64'd15);
    check("sat clear w32 data", 64'(rsp_data), 64'd20);
    do_read(0, 1'b0, d, d4, e);
    check("sat resume w4", d4, 64'd1);
    check("sat resume w32", d, 64'd1);

    // Response stall with the next request held, then release.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 8'd0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    l0_ev[0].l0_miss = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall%0d rsp_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("stall%0d rsp_data", c), 64'(rsp_data), 64'd1);
      check($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'd0);
    end
    l0_ev[0].l0_miss = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("release req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("release rsp_valid", 64'(rsp_valid), 64'd1);
    check("release rsp_data", 64'(rsp_data), 64'd4);

    // Global enable low blocks every counter.
    do_reset();
    enable = 1'b0;
    l0_ev = '1;
    l1_ev = '1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    l0_ev = '0;
    l1_ev = '0;
    for (int i = 0; i < 14; i++) begin
      do_read(i, 1'b0, d, d4, e);
      check($sformatf("disabled cnt %0d", i), d, 64'd0);
    end

    // Reset drops a stalled response.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 8'd3;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre-reset rsp_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid reset req_ready", 64'(req_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
